// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: CPU datapath (port 0) and loader/DMA (port 1)
// share one memory. Round-robin ownership with a bounded burst when the
// other port is waiting; read data is returned to the owning port one
// cycle after the transfer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, no grants, no memory strobes; arbitrate requests
// OWN0  | port 0 owns the memory; gnt0 follows req0
// OWN1  | port 1 owns the memory; gnt1 follows req1
module mem_port_arbiter #(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   // Encoding doubles as the owner code (00 idle, 01 port0, 10 port1).
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   logic [1:0]       state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] burst_cnt, cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cur_req, cur_we, other_req, burst_hit;

   // Select the owning port's request and the competing port's request.
   always_comb begin
      cur_req   = 1'b0;
      cur_we    = 1'b0;
      other_req = 1'b0;
      case (state)
         OWN0: begin
            cur_req   = req0;
            cur_we    = we0;
            other_req = req1;
         end
         OWN1: begin
            cur_req   = req1;
            cur_we    = we1;
            other_req = req0;
         end
         default: ;
      endcase
   end

   // Grants and memory-side mux; everything is quiet outside an OWN state.
   always_comb begin
      gnt0           = 1'b0;
      gnt1           = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      case (state)
         OWN0: begin
            gnt0           = req0;
            mem_address    = addr0;
            mem_write_data = wdata0;
            mem_read       = req0 & ~we0;
            mem_write      = req0 & we0;
         end
         OWN1: begin
            gnt1           = req1;
            mem_address    = addr1;
            mem_write_data = wdata1;
            mem_read       = req1 & ~we1;
            mem_write      = req1 & we1;
         end
         default: ;
      endcase
      owner = state;
   end

   // Burst counting saturates so a lone requester never wraps the count.
   always_comb begin
      cnt_inc   = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
      burst_hit = cur_req && (cnt_inc == MAX_CNT);
   end

   // Next-state: tie in IDLE goes to the port that did not own last.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = burst_cnt;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last))
               state_nxt = OWN0;
            else if (req1)
               state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (other_req && (!cur_req || burst_hit)) begin
               state_nxt = (state == OWN0) ? OWN1 : OWN0;
               last_nxt  = (state == OWN1);
               cnt_nxt   = '0;
            end else if (!cur_req && !other_req) begin
               state_nxt = IDLE;
               last_nxt  = (state == OWN1);
               cnt_nxt   = '0;
            end else if (cur_req) begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Arbitration state; last starts at 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   // Capture read data per port; rdata holds until that port reads again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= gnt0 & ~cur_we;
         rvalid1 <= gnt1 & ~cur_we;
         if (gnt0 && !cur_we)
            rdata0 <= mem_rdata;
         if (gnt1 && !cur_we)
            rdata1 <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [12:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
   logic [7:0]  rdata0, rdata1, mem_write_data, mem_rdata;
   logic [12:0] mem_address;
   logic [1:0]  owner;

   logic [7:0]  mem [0:8191];
   int          total = 0;
   int          bad = 0;

   mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_address];

   always @(posedge clk)
      if (mem_write) mem[mem_address] <= mem_write_data;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst  = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({owner, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 8'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=0", {owner, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write});
      end
      total++;
      if ({rdata0, rdata1, mem_address, mem_write_data} !== 37'b0) begin
         bad++;
         $display("FAIL reset_data got=%h exp=0", {rdata0, rdata1, mem_address, mem_write_data});
      end
   endtask

   task automatic test_single_read;
      do_reset();
      mem[5] = 8'hA3;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0005;
      @(negedge clk);
      total++;
      if ({owner, gnt0} !== 3'b000) begin
         bad++; $display("FAIL read_latency got=%b exp=000", {owner, gnt0});
      end
      tick();
      @(negedge clk);
      total++;
      if ({owner, gnt0, mem_read, mem_write, mem_address} !== {2'b01, 1'b1, 1'b1, 1'b0, 13'h0005}) begin
         bad++;
         $display("FAIL read_grant got=%b/%b/%b/%b/%h exp=01/1/1/0/0005", owner, gnt0, mem_read, mem_write, mem_address);
      end
      tick();
      req0 = 1'b0;
      @(negedge clk);
      total++;
      if ({rvalid0, rdata0} !== {1'b1, 8'hA3}) begin
         bad++; $display("FAIL read_data got=%b/%h exp=1/a3", rvalid0, rdata0);
      end
      tick();
      @(negedge clk);
      total++;
      if ({rvalid0, rdata0, owner} !== {1'b0, 8'hA3, 2'b00}) begin
         bad++; $display("FAIL read_hold got=%b/%h/%b exp=0/a3/00", rvalid0, rdata0, owner);
      end
   endtask

   task automatic test_round_robin;
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0100; wdata0 = 8'h01;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0200; wdata1 = 8'h02;
      tick();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         total++;
         if ({gnt0, gnt1} !== (((k / 4) % 2 == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_cycle%0d got=%b%b exp=%b", k, gnt0, gnt1, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
         end
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   task automatic test_lone_burst;
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h1000; wdata1 = 8'h10;
      tick();
      for (int i = 0; i < 10; i++) begin
         addr1 = 13'h1000 + 13'(i);
         wdata1 = 8'h10 + 8'(i);
         @(negedge clk);
         total++;
         if ({gnt1, gnt0, owner, rvalid1, mem_write} !== {1'b1, 1'b0, 2'b10, 1'b0, 1'b1}) begin
            bad++; $display("FAIL lone_cycle%0d got=%b%b/%b/%b/%b exp=10/10/0/1", i, gnt1, gnt0, owner, rvalid1, mem_write);
         end
         tick();
      end
      req1 = 1'b0;
      @(negedge clk);
      total++;
      if (rvalid1 !== 1'b0) begin
         bad++; $display("FAIL lone_no_rvalid got=%b exp=0", rvalid1);
      end
      for (int i = 0; i < 10; i++) begin
         total++;
         if (mem[13'h1000 + 13'(i)] !== 8'h10 + 8'(i)) begin
            bad++; $display("FAIL lone_mem%0d got=%h exp=%h", i, mem[13'h1000 + 13'(i)], 8'h10 + 8'(i));
         end
      end
      tick();
   endtask

   task automatic test_switch;
      do_reset();
      mem[13'h0020] = 8'h11;
      mem[13'h0021] = 8'h22;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0020;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0030; wdata1 = 8'h55;
      tick();
      @(negedge clk);
      total++;
      if ({owner, gnt0, gnt1} !== 4'b0110) begin
         bad++; $display("FAIL sw_first got=%b/%b%b exp=01/10", owner, gnt0, gnt1);
      end
      tick();
      addr0 = 13'h0021;
      @(negedge clk);
      total++;
      if ({gnt0, rvalid0, rdata0} !== {1'b1, 1'b1, 8'h11}) begin
         bad++; $display("FAIL sw_read1 got=%b/%b/%h exp=1/1/11", gnt0, rvalid0, rdata0);
      end
      tick();
      req0 = 1'b0;
      @(negedge clk);
      total++;
      if ({owner, gnt0, gnt1, rvalid0, rdata0} !== {2'b01, 1'b0, 1'b0, 1'b1, 8'h22}) begin
         bad++; $display("FAIL sw_drop got=%b/%b%b/%b/%h exp=01/00/1/22", owner, gnt0, gnt1, rvalid0, rdata0);
      end
      tick();
      @(negedge clk);
      total++;
      if ({owner, gnt1, gnt0, mem_write} !== {2'b10, 1'b1, 1'b0, 1'b1}) begin
         bad++; $display("FAIL sw_new_owner got=%b/%b%b/%b exp=10/10/1", owner, gnt1, gnt0, mem_write);
      end
      tick();
      req1 = 1'b0;
      @(negedge clk);
      total++;
      if ({rvalid0, rdata0, mem[13'h0030]} !== {1'b0, 8'h22, 8'h55}) begin
         bad++; $display("FAIL sw_after got=%b/%h/%h exp=0/22/55", rvalid0, rdata0, mem[13'h0030]);
      end
      tick();
   endtask

   task automatic test_async_reset;
      do_reset();
      mem[13'h0040] = 8'h77;
      req1 = 1'b1; we1 = 1'b0; addr1 = 13'h0040;
      tick();
      @(negedge clk);
      total++;
      if ({gnt1, mem_read} !== 2'b11) begin
         bad++; $display("FAIL ar_pre got=%b%b exp=11", gnt1, mem_read);
      end
      #1 rst = 1'b0;
      #1;
      total++;
      if ({owner, gnt1, mem_read, rvalid1, mem_address, rdata1} !== 27'b0) begin
         bad++; $display("FAIL ar_immediate got=%b/%b/%b/%b/%h/%h exp=0", owner, gnt1, mem_read, rvalid1, mem_address, rdata1);
      end
      tick();
      rst = 1'b1;
      req1 = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({rvalid1, rdata1} !== 9'b0) begin
         bad++; $display("FAIL ar_no_rvalid got=%b/%h exp=0/00", rvalid1, rdata1);
      end
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0050; wdata0 = 8'h05;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0060; wdata1 = 8'h06;
      tick();
      @(negedge clk);
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++; $display("FAIL ar_tie got=%b%b exp=10", gnt0, gnt1);
      end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   task automatic test_pulse;
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0007;
      tick();
      req0 = 1'b0;
      @(negedge clk);
      total++;
      if ({owner, gnt0, mem_read, mem_write} !== 5'b01000) begin
         bad++; $display("FAIL pulse_own got=%b/%b/%b%b exp=01/0/00", owner, gnt0, mem_read, mem_write);
      end
      tick();
      @(negedge clk);
      total++;
      if ({owner, rvalid0} !== 3'b000) begin
         bad++; $display("FAIL pulse_idle got=%b/%b exp=00/0", owner, rvalid0);
      end
      req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0070; wdata0 = 8'h07;
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0080; wdata1 = 8'h08;
      tick();
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, owner} !== 4'b0110) begin
         bad++; $display("FAIL pulse_tie got=%b%b/%b exp=01/10", gnt0, gnt1, owner);
      end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
      test_reset();
      test_single_read();
      test_round_robin();
      test_lone_burst();
      test_switch();
      test_async_reset();
      test_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
